// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and one-hot FSM states.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CALC  = 4'b0010,
    S_FIXUP = 4'b0100,
    S_DONE  = 4'b1000
  } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Two's-complement conditional negate, used for operand magnitudes and result sign fixup.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Handshake: start is taken only in IDLE; busy stays high until and including the done cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e r_state;
  mdu_state_e w_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  mdu_op_e          w_op;
  logic             w_is_div;
  logic             w_signed;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_accept;
  logic             w_last;
  logic             w_finish;

  assign w_op     = mdu_op_e'(op);
  assign w_is_div = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
  assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
  assign w_sign_a = w_signed & src_a[WIDTH-1];
  assign w_sign_b = w_signed & src_b[WIDTH-1];
  assign w_accept = (r_state == S_IDLE) && start && !cancel;
  assign w_last   = (r_cnt == CNT_W'(1));
  assign w_finish = (r_state == S_FIXUP) && !cancel;

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_sign_a), .i_val(src_a), .o_val(w_abs_a));
  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_sign_b), .i_val(src_b), .o_val(w_abs_b));

  // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts in quotient bits.
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_step;
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_trial - {1'b0, r_opnd};
  assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
  assign w_div_step  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_neg(!r_is_div && r_neg_q), .i_val(r_acc), .o_val(w_prod_fix)
  );
  // A zero divisor returns the raw algorithm output, so sign fixup is suppressed.
  mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg(r_neg_q && !r_b_zero), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quo_fix)
  );
  mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg(r_neg_r && !r_b_zero), .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem_fix)
  );

  assign w_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (cancel)      w_next = S_IDLE;
        else if (w_last) w_next = S_FIXUP;
      end
      S_FIXUP: w_next = cancel ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= CNT_W'(WIDTH);
      r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
      r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
      r_is_div <= w_is_div;
      r_neg_q  <= w_sign_a ^ w_sign_b;
      r_neg_r  <= w_sign_a;
      r_b_zero <= (src_b == '0);
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_acc <= r_is_div ? w_div_step : w_mul_step;
    end
  end

  // A finishing result takes priority over a coincident MTHI/MTLO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else begin
      if (hi_wen) r_hi <= wdata;
      if (lo_wen) r_lo <= wdata;
    end
  end

  assign busy      = !r_state[0];
  assign done      = r_state[3];
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: a 32-bit instance plus an 8-bit instance.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        hi_wen = 1'b0;
  logic        lo_wen = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [3:0]  dbg_state;

  logic        start8 = 1'b0;
  logic [7:0]  src_a8 = '0;
  logic [7:0]  src_b8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;
  logic [3:0]  dbg_state8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  mul_div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .src_a(src_a8), .src_b(src_b8),
    .cancel(1'b0), .hi_wen(1'b0), .lo_wen(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbg_state(dbg_state8)
  );

  // Returns in the first cycle after the start edge (cycle 1).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; op = o; src_a8 = a; src_b8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Cycle number (start edge cycle = 1) in which done is seen; 999 if it never comes.
  task automatic wait_done(input bit narrow, output int lat);
    lat = 1;
    while (!(narrow ? done8 : done) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!(narrow ? done8 : done)) lat = 999;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_mult;
    int lat;
    launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_c1: got %b want 1", busy); end
    wait_done(1'b0, lat);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL mult_latency: got %0d want 34", lat); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_done: got %b want 1", busy); end
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
    n_vec++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFF_FFFE); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mult_after: got done=%b busy=%b want 0 0", done, busy); end

    launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(1'b0, lat);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL multu_latency: got %0d want 34", lat); end
    n_vec++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi: got %h want %h", hi, 32'h1); end
    n_vec++; if (lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h want %h", lo, 32'hFFFF_FFFE); end
  endtask

  task automatic test_div;
    int lat;
    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1'b0, lat);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL div_latency: got %0d want 34", lat); end
    n_vec++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
    n_vec++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want %h", hi, 32'hFFFF_FFFF); end

    launch(2'b11, 32'd100, 32'd7);
    wait_done(1'b0, lat);
    n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h want %h", lo, 32'd14); end
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_div_edge;
    int lat;
    launch(2'b11, 32'h0000_0064, 32'h0000_0000);
    wait_done(1'b0, lat);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL divz_latency: got %0d want 34", lat); end
    n_vec++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
    n_vec++; if (hi !== 32'h0000_0064) begin n_err++; $display("FAIL divz_hi: got %h want %h", hi, 32'h64); end

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat);
    n_vec++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want %h", lo, 32'h8000_0000); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi: got %h want %h", hi, 32'h0); end
  endtask

  task automatic test_cancel;
    int lat;
    int n_done;
    @(negedge clk);
    hi_wen = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_wen = 1'b0;
    n_vec++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_idle: got %h want %h", hi, 32'h1234); end

    launch(2'b00, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b want 0", busy); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL cancel_no_done: got %0d pulses want 0", n_done); end
    n_vec++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL cancel_hi: got %h want %h", hi, 32'h1234); end
    n_vec++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL cancel_lo: got %h want %h", lo, 32'h8000_0000); end

    launch(2'b01, 32'd3, 32'd5);
    wait_done(1'b0, lat);
    n_vec++; if (lat !== 34) begin n_err++; $display("FAIL restart_latency: got %0d want 34", lat); end
    n_vec++; if (lo !== 32'd15 || hi !== 32'd0) begin n_err++; $display("FAIL restart_result: got hi=%h lo=%h want 0 f", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int n_done;
    launch(2'b01, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'd100; src_b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    lo_wen = 1'b1; wdata = 32'h0000_00AA;
    @(negedge clk);
    lo_wen = 1'b0;
    n_vec++; if (lo !== 32'h0000_00AA) begin n_err++; $display("FAIL mtlo_busy: got %h want %h", lo, 32'hAA); end
    repeat (12) @(negedge clk);
    lo_wen = 1'b1; hi_wen = 1'b1; wdata = 32'h0000_0055;
    @(negedge clk);
    lo_wen = 1'b0; hi_wen = 1'b0;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_c34: got %b want 1", done); end
    n_vec++; if (lo !== 32'd42) begin n_err++; $display("FAIL b2b_lo: got %h want %h", lo, 32'd42); end
    n_vec++; if (hi !== 32'd0) begin n_err++; $display("FAIL b2b_hi: got %h want %h", hi, 32'd0); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL b2b_no_second: got %0d busy/done cycles want 0", n_done); end
  endtask

  task automatic test_reset_mid;
    int n_done;
    launch(2'b11, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rstmid_hilo: got hi=%h lo=%h want 0 0", hi, lo); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n_done); end
  endtask

  task automatic test_width8;
    int lat;
    launch8(2'b00, 8'h80, 8'h80);
    wait_done(1'b1, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL w8_latency: got %0d want 10", lat); end
    n_vec++; if (hi8 !== 8'h40) begin n_err++; $display("FAIL w8_hi: got %h want %h", hi8, 8'h40); end
    n_vec++; if (lo8 !== 8'h00) begin n_err++; $display("FAIL w8_lo: got %h want %h", lo8, 8'h00); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_edge;
    test_cancel;
    test_back_to_back;
    test_reset_mid;
    test_width8;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
